// File: rtl/interrupt_controller.sv
// Two-level vectored interrupt controller: synchronised edge-triggered requests,
// INT0-over-INT1 priority with nesting, and a deferred return-from-interrupt phase.
module interrupt_controller (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       FETCH,
    input  logic       DECODE,
    input  logic       PC_ENX,
    input  logic       INT0_REQ,
    input  logic       INT1_REQ,
    input  logic       RETI,
    input  logic       EI,
    input  logic       DI,
    output logic [2:0] PC_NEXTX,
    output logic       PC_LD_INT0X,
    output logic       PC_LD_INT1X,
    output logic       INT0_ACK,
    output logic       INT1_ACK,
    output logic       INT0_ACTIVE,
    output logic       INT1_ACTIVE,
    output logic       GIE
);

    localparam logic [2:0] PC_NEXTX_NEXT  = 3'd0;
    localparam logic [2:0] PC_NEXTX_INTV0 = 3'd1;
    localparam logic [2:0] PC_NEXTX_INTV1 = 3'd2;
    localparam logic [2:0] PC_NEXTX_INTR0 = 3'd3;
    localparam logic [2:0] PC_NEXTX_INTR1 = 3'd4;

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_RETPEND = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [1:0] int0_sync_r;
    logic [1:0] int1_sync_r;
    logic       int0_prev_r;
    logic       int1_prev_r;
    logic [1:0] arm_cnt_r;
    logic       pend0_r;
    logic       pend1_r;
    logic       act0_r;
    logic       act1_r;
    logic       gie_r;
    logic       ack0_r;
    logic       ack1_r;
    logic       edge0_s;
    logic       edge1_s;
    logic       commit_s;
    logic       elig0_s;
    logic       elig1_s;
    logic       take0_s;
    logic       take1_s;
    logic       ret0_s;
    logic       ret1_s;
    logic [2:0] pc_nextx_s;

    // Request synchronisers; edges stay masked until the pipeline holds post-reset samples.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            int0_sync_r <= 2'b00;
            int1_sync_r <= 2'b00;
            int0_prev_r <= 1'b0;
            int1_prev_r <= 1'b0;
            arm_cnt_r   <= 2'd0;
        end else begin
            int0_sync_r <= {int0_sync_r[0], INT0_REQ};
            int1_sync_r <= {int1_sync_r[0], INT1_REQ};
            int0_prev_r <= int0_sync_r[1];
            int1_prev_r <= int1_sync_r[1];
            if (arm_cnt_r != 2'd3) begin
                arm_cnt_r <= arm_cnt_r + 2'd1;
            end else begin
                arm_cnt_r <= arm_cnt_r;
            end
        end
    end

    // Edge detection and priority eligibility.
    always_comb begin
        edge0_s  = (arm_cnt_r == 2'd3) & int0_sync_r[1] & ~int0_prev_r;
        edge1_s  = (arm_cnt_r == 2'd3) & int1_sync_r[1] & ~int1_prev_r;
        commit_s = FETCH & PC_ENX;
        elig0_s  = pend0_r & gie_r & ~act0_r;
        elig1_s  = pend1_r & gie_r & ~act0_r & ~act1_r;
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (DECODE & RETI & (act0_r | act1_r)) begin
                    state_nxt_s = ST_RETPEND;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RETPEND: begin
                if (commit_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_RETPEND;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Output selection: vectoring in RUN, return address in RETPEND, otherwise sequential.
    always_comb begin
        pc_nextx_s = PC_NEXTX_NEXT;
        take0_s    = 1'b0;
        take1_s    = 1'b0;
        ret0_s     = 1'b0;
        ret1_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (commit_s & elig0_s) begin
                    take0_s    = 1'b1;
                    pc_nextx_s = PC_NEXTX_INTV0;
                end else if (commit_s & elig1_s) begin
                    take1_s    = 1'b1;
                    pc_nextx_s = PC_NEXTX_INTV1;
                end else begin
                    pc_nextx_s = PC_NEXTX_NEXT;
                end
            end
            ST_RETPEND: begin
                if (commit_s & act0_r) begin
                    ret0_s     = 1'b1;
                    pc_nextx_s = PC_NEXTX_INTR0;
                end else if (commit_s) begin
                    ret1_s     = 1'b1;
                    pc_nextx_s = PC_NEXTX_INTR1;
                end else begin
                    pc_nextx_s = PC_NEXTX_NEXT;
                end
            end
            default: pc_nextx_s = PC_NEXTX_NEXT;
        endcase
    end

    // Pending, in-service, acknowledge and global-enable flags; a new edge beats an acknowledge clear.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pend0_r <= 1'b0;
            pend1_r <= 1'b0;
            act0_r  <= 1'b0;
            act1_r  <= 1'b0;
            ack0_r  <= 1'b0;
            ack1_r  <= 1'b0;
            gie_r   <= 1'b0;
        end else begin
            pend0_r <= edge0_s | (pend0_r & ~take0_s);
            pend1_r <= edge1_s | (pend1_r & ~take1_s);
            act0_r  <= take0_s | (act0_r & ~ret0_s);
            act1_r  <= take1_s | (act1_r & ~ret1_s);
            ack0_r  <= take0_s;
            ack1_r  <= take1_s;
            if (DECODE & DI) begin
                gie_r <= 1'b0;
            end else if (DECODE & EI) begin
                gie_r <= 1'b1;
            end else begin
                gie_r <= gie_r;
            end
        end
    end

    assign PC_NEXTX    = pc_nextx_s;
    assign PC_LD_INT0X = take0_s;
    assign PC_LD_INT1X = take1_s;
    assign INT0_ACK    = ack0_r;
    assign INT1_ACK    = ack1_r;
    assign INT0_ACTIVE = act0_r;
    assign INT1_ACTIVE = act1_r;
    assign GIE         = gie_r;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: per-cycle expected output vectors are queued
// as each step is driven and popped when the outputs are sampled.
module tb_interrupt_controller;

    localparam logic [2:0] NXT = 3'd0;
    localparam logic [2:0] IV0 = 3'd1;
    localparam logic [2:0] IV1 = 3'd2;
    localparam logic [2:0] IR0 = 3'd3;
    localparam logic [2:0] IR1 = 3'd4;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       FETCH = 1'b0;
    logic       DECODE = 1'b0;
    logic       PC_ENX = 1'b0;
    logic       INT0_REQ = 1'b0;
    logic       INT1_REQ = 1'b0;
    logic       RETI = 1'b0;
    logic       EI = 1'b0;
    logic       DI = 1'b0;
    logic [2:0] PC_NEXTX;
    logic       PC_LD_INT0X;
    logic       PC_LD_INT1X;
    logic       INT0_ACK;
    logic       INT1_ACK;
    logic       INT0_ACTIVE;
    logic       INT1_ACTIVE;
    logic       GIE;

    typedef struct {
        string      tag;
        logic [9:0] exp;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int        checks = 0;
    int        errors = 0;

    interrupt_controller dut (
        .CLK(CLK), .RESET(RESET), .FETCH(FETCH), .DECODE(DECODE), .PC_ENX(PC_ENX),
        .INT0_REQ(INT0_REQ), .INT1_REQ(INT1_REQ), .RETI(RETI), .EI(EI), .DI(DI),
        .PC_NEXTX(PC_NEXTX), .PC_LD_INT0X(PC_LD_INT0X), .PC_LD_INT1X(PC_LD_INT1X),
        .INT0_ACK(INT0_ACK), .INT1_ACK(INT1_ACK), .INT0_ACTIVE(INT0_ACTIVE),
        .INT1_ACTIVE(INT1_ACTIVE), .GIE(GIE)
    );

    always #5 CLK = ~CLK;

    // Vector layout: {pc[2:0], ld0, ld1, ack0, ack1, act0, act1, gie}
    function automatic logic [9:0] v(input logic [2:0] pc, input logic ld0, input logic ld1,
                                     input logic k0, input logic k1, input logic a0,
                                     input logic a1, input logic g);
        return {pc, ld0, ld1, k0, k1, a0, a1, g};
    endfunction

    // One cycle: drive at the falling edge, queue the expectation, sample 1 time unit later.
    task automatic step(input logic rst, input logic f, input logic en, input logic d,
                        input logic r, input logic e, input logic di_v,
                        input logic [9:0] exp, input string tag);
        sb_entry_t ent;
        logic [9:0] obs;
        @(negedge CLK);
        RESET = rst; FETCH = f; PC_ENX = en; DECODE = d; RETI = r; EI = e; DI = di_v;
        ent.tag = tag;
        ent.exp = exp;
        sb_q.push_back(ent);
        #1;
        obs = {PC_NEXTX, PC_LD_INT0X, PC_LD_INT1X, INT0_ACK, INT1_ACK,
               INT0_ACTIVE, INT1_ACTIVE, GIE};
        ent = sb_q.pop_front();
        checks++;
        assert (obs === ent.exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b (pc,ld0,ld1,ack0,ack1,act0,act1,gie)",
                   ent.tag, obs, ent.exp);
        end
    endtask

    task automatic idle(input int n, input logic [9:0] exp, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, exp, tag);
    endtask

    task automatic fet(input logic en, input logic [9:0] exp, input string tag);
        step(1'b1, 1'b1, en, 1'b0, 1'b0, 1'b0, 1'b0, exp, tag);
    endtask

    task automatic dec(input logic r, input logic e, input logic di_v,
                       input logic [9:0] exp, input string tag);
        step(1'b1, 1'b0, 1'b0, 1'b1, r, e, di_v, exp, tag);
    endtask

    initial begin
        logic [9:0] z;
        logic [9:0] g;
        z = v(NXT, 0, 0, 0, 0, 0, 0, 0);
        g = v(NXT, 0, 0, 0, 0, 0, 0, 1);

        // Reset state, request held high across release
        INT0_REQ = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z, "rst_state");
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, z, "rst_fetch");
        idle(4, z, "post_rst_idle");
        dec(0, 1, 0, z, "ei");
        fet(1, g, "no_edge_across_reset");
        INT0_REQ = 1'b0;
        idle(4, g, "idle_gie");

        // Basic INT1 with a stalled fetch in RETPEND
        INT1_REQ = 1'b1;
        idle(4, g, "int1_sync");
        fet(1, v(IV1, 0, 1, 0, 0, 0, 0, 1), "int1_vec");
        idle(1, v(NXT, 0, 0, 0, 1, 0, 1, 1), "int1_ack");
        idle(1, v(NXT, 0, 0, 0, 0, 0, 1, 1), "int1_ack_done");
        dec(1, 0, 0, v(NXT, 0, 0, 0, 0, 0, 1, 1), "int1_reti");
        fet(0, v(NXT, 0, 0, 0, 0, 0, 1, 1), "retpend_stall");
        fet(1, v(IR1, 0, 0, 0, 0, 0, 1, 1), "int1_ret");
        idle(1, g, "int1_cleared");
        INT1_REQ = 1'b0;
        dec(1, 0, 0, g, "reti_idle");
        fet(1, g, "reti_ignored");

        // Simultaneous requests: INT0 first, INT1 after INT0 returns
        INT0_REQ = 1'b1;
        INT1_REQ = 1'b1;
        idle(4, g, "sim_sync");
        fet(1, v(IV0, 1, 0, 0, 0, 0, 0, 1), "sim_v0");
        idle(1, v(NXT, 0, 0, 1, 0, 1, 0, 1), "sim_ack0");
        fet(1, v(NXT, 0, 0, 0, 0, 1, 0, 1), "int1_blocked_by_act0");
        dec(1, 0, 0, v(NXT, 0, 0, 0, 0, 1, 0, 1), "sim_reti");
        fet(1, v(IR0, 0, 0, 0, 0, 1, 0, 1), "sim_r0");
        fet(1, v(IV1, 0, 1, 0, 0, 0, 0, 1), "sim_v1_after");
        idle(1, v(NXT, 0, 0, 0, 1, 0, 1, 1), "sim_ack1");
        INT0_REQ = 1'b0;
        INT1_REQ = 1'b0;
        idle(2, v(NXT, 0, 0, 0, 0, 0, 1, 1), "req_low");

        // Nesting: INT0 pre-empts the running INT1 handler
        INT0_REQ = 1'b1;
        idle(4, v(NXT, 0, 0, 0, 0, 0, 1, 1), "nest_sync");
        fet(1, v(IV0, 1, 0, 0, 0, 0, 1, 1), "nest_v0");
        idle(1, v(NXT, 0, 0, 1, 0, 1, 1, 1), "nest_ack0");
        dec(1, 0, 0, v(NXT, 0, 0, 0, 0, 1, 1, 1), "nest_reti0");
        fet(1, v(IR0, 0, 0, 0, 0, 1, 1, 1), "nest_r0");
        dec(1, 0, 0, v(NXT, 0, 0, 0, 0, 0, 1, 1), "nest_reti1");
        fet(1, v(IR1, 0, 0, 0, 0, 0, 1, 1), "nest_r1");
        idle(1, g, "nest_done");
        INT0_REQ = 1'b0;

        // Masking: recorded while GIE=0, DI beats EI, serviced after EI
        dec(0, 0, 1, g, "di");
        INT0_REQ = 1'b1;
        idle(4, z, "mask_sync");
        for (int i = 0; i < 10; i++) fet(1, z, "mask_fetch");
        dec(0, 1, 1, z, "ei_di");
        fet(1, z, "ei_di_keeps_gie0");
        dec(0, 1, 0, z, "ei_alone");
        fet(1, v(IV0, 1, 0, 0, 0, 0, 0, 1), "mask_v0");
        idle(1, v(NXT, 0, 0, 1, 0, 1, 0, 1), "mask_ack0");
        dec(1, 0, 0, v(NXT, 0, 0, 0, 0, 1, 0, 1), "mask_reti");
        fet(1, v(IR0, 0, 0, 0, 0, 1, 0, 1), "mask_r0");
        idle(1, g, "mask_done");
        INT0_REQ = 1'b0;
        idle(2, g, "req_low2");

        // Stall with pending INT0, then reset during RETPEND
        INT0_REQ = 1'b1;
        idle(4, g, "stall_sync");
        fet(0, g, "stall_pc_next");
        idle(1, g, "stall_no_ack");
        fet(1, v(IV0, 1, 0, 0, 0, 0, 0, 1), "stall_v0");
        idle(1, v(NXT, 0, 0, 1, 0, 1, 0, 1), "stall_ack0");
        dec(1, 0, 0, v(NXT, 0, 0, 0, 0, 1, 0, 1), "stall_reti");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z, "rst_in_retpend");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, z, "rst_held");
        idle(3, z, "rst_release");
        fet(1, z, "post_rst_fetch_next");
        INT0_REQ = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with the ports listed below.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RESET  input  1  asynchronous, active-low reset.
REQ-004 FETCH, DECODE  input  1 each  sequencer phase strobes; at most one is high in any cycle.
REQ-005 PC_ENX  input  1  program-counter update enable; redirects are committed only when FETCH & PC_ENX.
REQ-006 INT0_REQ, INT1_REQ  input  1 each  asynchronous external requests, rising-edge significant.
REQ-007 RETI  input  1  return-from-interrupt, asserted by the decoder during DECODE.
REQ-008 EI, DI  input  1 each  global enable set/clear, sampled during DECODE.
REQ-009 PC_NEXTX  output  3  next-address select to the program counter, encoded with the shared PC_NEXTX_* constants.
REQ-010 PC_LD_INT0X, PC_LD_INT1X  output  1 each  return-address capture strobes to the program counter.
REQ-011 INT0_ACK, INT1_ACK  output  1 each  one-cycle acknowledge pulses.
REQ-012 INT0_ACTIVE, INT1_ACTIVE, GIE  output  1 each  handler-in-service flags and the global enable.

Function
REQ-013 Each INTn_REQ SHALL pass through a 2-flop synchroniser, then a rising-edge detector.
  - A detected edge sets PENDn.
  - A new edge while PENDn is already set is absorbed; there is no counting.
REQ-014 Eligibility:
  - INT0 is eligible when PEND0 & GIE & !ACTIVE0.
  - INT1 is eligible when PEND1 & GIE & !ACTIVE0 & !ACTIVE1.
  - INT0 has priority over INT1 and may pre-empt an INT1 handler; INT1 never pre-empts INT0; no level re-enters itself.
REQ-015 Output selection SHALL be combinational from registered state, FETCH and PC_ENX. The states are RUN and RETPEND.
REQ-016 In RUN, with FETCH & PC_ENX and INT0 eligible:
  - PC_NEXTX = INTV0 and PC_LD_INT0X = 1 for that cycle.
  - On the clock edge: ACTIVE0 sets, PEND0 clears, and INT0_ACK pulses high for the following cycle.
REQ-017 In RUN, with FETCH & PC_ENX and only INT1 eligible, the block SHALL behave as REQ-016 using INTV1, PC_LD_INT1X, ACTIVE1, PEND1 and INT1_ACK.
REQ-018 RETI during DECODE with ACTIVE0 | ACTIVE1 SHALL move the state to RETPEND. RETI with no active level SHALL be ignored.
REQ-019 In RETPEND, on FETCH & PC_ENX:
  - PC_NEXTX = INTR0 if ACTIVE0, else INTR1.
  - That ACTIVE flag clears and the state returns to RUN.
  - No interrupt is vectored in the same FETCH; pending requests are considered at the next FETCH.
REQ-020 In RETPEND, a FETCH with PC_ENX low SHALL hold the state; no flags change.
REQ-021 In every other case PC_NEXTX SHALL equal PC_NEXTX_NEXT and both PC_LD_INTnX SHALL be 0.
  - This includes FETCH low, or FETCH with PC_ENX low.
REQ-022 GIE SHALL update on DECODE:
  - EI sets GIE and DI clears it; if both are asserted, DI wins.
  - Vectoring does not alter GIE.
REQ-023 A request edge arriving in the same cycle that PENDn is cleared by acknowledge SHALL leave PENDn set; the set takes precedence.
REQ-024 PENDn SHALL be recorded while GIE = 0 and serviced once GIE = 1.

Reset
REQ-025 While RESET is low, the following SHALL be forced immediately: state RUN; PEND0/1 = 0; ACTIVE0/1 = 0; GIE = 0; ACK = 0; synchroniser and edge flops = 0.
REQ-026 After reset, PC_NEXTX SHALL equal PC_NEXTX_NEXT and the LD strobes SHALL be 0.
REQ-027 A reset asserted mid-handler or in RETPEND SHALL discard all in-service state.
REQ-028 A request that is high across reset release SHALL NOT generate an edge.

Verification
REQ-029 Basic INT1: EI, then INT1_REQ 0->1, then FETCH & PC_ENX.
  - Expect PC_NEXTX = INTV1 and PC_LD_INT1X = 1 in that cycle, INT1_ACK one cycle later, ACTIVE1 = 1.
  - Then RETI at DECODE and the next FETCH: expect PC_NEXTX = INTR1 and ACTIVE1 = 0.
REQ-030 Simultaneous requests: INT0 and INT1 rise in the same cycle with GIE = 1.
  - First FETCH selects INTV0.
  - INT1 stays pending until RETI restores INTR0; it vectors on the FETCH after that restore.
REQ-031 Nesting: INT0 edge while ACTIVE1 = 1.
  - Expect vector to INTV0, then RETI restores INTR0 and a second RETI restores INTR1.
  - Conversely, an INT1 edge during ACTIVE0 is not taken until ACTIVE0 clears.
REQ-032 Masking: GIE = 0 with INT0 edge.
  - Expect no vectoring over 10 FETCHes; EI with DI in the same DECODE keeps GIE = 0.
  - EI alone, then the next FETCH gives INTV0.
REQ-033 Stall and reset: FETCH with PC_ENX = 0 while PEND0 = 1.
  - Expect PC_NEXTX = NEXT and no LD or ACK.
  - RESET pulsed low during RETPEND: all flags 0, and the next FETCH gives NEXT.
